// File: rtl/ram_arbiter.sv
// Round-robin arbiter that serialises NREQ cache miss ports onto one shared RAM port.
// Define DATA_PRIORITY_EN to favour odd (data) requesters over even (instruction) ones.
module ram_arbiter #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [NREQ-1:0]        req_ren,
  input  logic [NREQ-1:0]        req_wen,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_store,
  output logic [NREQ-1:0]        req_wait,
  output logic [NREQ-1:0]        req_hit,
  output logic [DATA_W-1:0]      req_load,
  output logic                   ram_ren,
  output logic                   ram_wen,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic [DATA_W-1:0]      ram_store,
  input  logic [DATA_W-1:0]      ram_load,
  input  logic                   ram_ready,
  output logic                   busy,
  output logic [ID_W-1:0]        grant_id
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [NREQ-1:0]   active;
  logic [NREQ-1:0]   cand;
  logic [ID_W-1:0]   pick;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_store;
  logic              win_wen;

  // First set bit of cand found scanning ptr, ptr+1, ... modulo NREQ.
  function automatic logic [ID_W-1:0] rr_select(input logic [NREQ-1:0] c,
                                                input logic [ID_W-1:0] ptr);
    logic [ID_W-1:0] sel;
    logic [ID_W-1:0] idx;
    logic            found;
    sel   = ptr;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = ID_W'((int'(ptr) + i) % NREQ);
      if (!found && c[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    return sel;
  endfunction

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
    int n;
    n = (int'(id) + 1) % NREQ;
    return ID_W'(n);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [ID_W-1:0] id);
    logic [NREQ-1:0] h;
    h     = '0;
    h[id] = 1'b1;
    return h;
  endfunction

`ifdef DATA_PRIORITY_EN
  function automatic logic [NREQ-1:0] odd_mask();
    logic [NREQ-1:0] m;
    m = '0;
    for (int i = 1; i < NREQ; i += 2) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [NREQ-1:0] DATA_PORTS = odd_mask();
`endif

  assign active   = req_ren | req_wen;
  assign req_wait = active & ~req_hit;

  always_comb begin
    cand = active;
`ifdef DATA_PRIORITY_EN
    if ((active & DATA_PORTS) != '0) cand = active & DATA_PORTS;
`endif
  end

  assign pick = rr_select(cand, rr_ptr);

  always_comb begin
    win_addr  = '0;
    win_store = '0;
    win_wen   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == ID_W'(i)) begin
        win_addr  = req_addr[i*ADDR_W +: ADDR_W];
        win_store = req_store[i*DATA_W +: DATA_W];
        win_wen   = req_wen[i];
      end
    end
  end

  // A write wins over a read when a requester raises both strobes.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      ram_ren   <= 1'b0;
      ram_wen   <= 1'b0;
      ram_addr  <= '0;
      ram_store <= '0;
      req_load  <= '0;
      req_hit   <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|active) begin
            grant_id  <= pick;
            ram_addr  <= win_addr;
            ram_store <= win_store;
            ram_wen   <= win_wen;
            ram_ren   <= ~win_wen;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (ram_ready) begin
            if (ram_ren) req_load <= ram_load;
            ram_ren <= 1'b0;
            ram_wen <= 1'b0;
            busy    <= 1'b0;
            rr_ptr  <= next_ptr(grant_id);
            req_hit <= onehot(grant_id);
            state   <= DONE;
          end
        end
        DONE: begin
          req_hit <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: rounds of held requests, random RAM latency/data,
// grant order predicted per round from the round-robin rule.
module tb_ram_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            CLK = 1'b0;
  logic            nRST;
  logic [N-1:0]    req_ren, req_wen, req_wait, req_hit;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_store;
  logic [DW-1:0]   req_load, ram_store, ram_load;
  logic [AW-1:0]   ram_addr;
  logic            ram_ren, ram_wen, ram_ready, busy;
  logic [IW-1:0]   grant_id;

  ram_arbiter #(.NREQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr), .req_store(req_store),
    .req_wait(req_wait), .req_hit(req_hit), .req_load(req_load),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_store(ram_store),
    .ram_load(ram_load), .ram_ready(ram_ready), .busy(busy), .grant_id(grant_id)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          id;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] store;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] r_addr[N];
  logic [31:0] r_store[N];
  logic [N-1:0] r_ren, r_wen, pending;
  int          model_rr;
  logic [31:0] resp_data;
  bit          in_txn, force_on, end_chk;
  int          cnt, force_d;
  logic [31:0] force_data;

  // Reference: the whole round's grant order from the set of held requests.
  task automatic plan_order(input logic [N-1:0] set);
    logic [N-1:0] left, cand;
    int ptr, w;
    exp_t e;
    left = set;
    ptr  = model_rr;
    while (left != 0) begin
      cand = left;
`ifdef DATA_PRIORITY_EN
      if ((left & 4'b1010) != 0) cand = left & 4'b1010;
`endif
      w = -1;
      for (int k = 0; k < N; k++) if (w < 0 && cand[(ptr + k) % N]) w = (ptr + k) % N;
      e.id = w; e.wr = r_wen[w]; e.addr = r_addr[w]; e.store = r_store[w];
      exp_q.push_back(e);
      left[w] = 1'b0;
      ptr = (w + 1) % N;
    end
    model_rr = ptr;
  endtask

  task automatic clear_r();
    r_ren = '0; r_wen = '0;
    for (int i = 0; i < N; i++) begin r_addr[i] = '0; r_store[i] = '0; end
  endtask

  task automatic set_req(input int i, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    r_ren[i] = rd; r_wen[i] = wr; r_addr[i] = a; r_store[i] = d;
  endtask

  task automatic issue();
    plan_order(r_ren | r_wen);
    for (int i = 0; i < N; i++) begin
      req_ren[i] = r_ren[i];
      req_wen[i] = r_wen[i];
      req_addr[i*AW +: AW]  = r_addr[i];
      req_store[i*DW +: DW] = r_store[i];
    end
    pending = r_ren | r_wen;
  endtask

  // One clock: RAM responder plus requesters dropping their request on hit.
  task automatic step();
    @(posedge CLK);
    #1;
    if ((ram_ren | ram_wen) && !in_txn) begin
      in_txn = 1'b1;
      cnt = force_on ? force_d : int'($urandom_range(0, 3));
    end
    if (in_txn && cnt == 0) begin
      resp_data = force_on ? force_data : $urandom;
      ram_load  = resp_data;
      ram_ready = 1'b1;
      in_txn    = 1'b0;
    end else begin
      if (in_txn) cnt--;
      ram_ready = 1'b0;
      ram_load  = $urandom;
    end
    for (int i = 0; i < N; i++) begin
      if (req_hit[i]) begin
        req_ren[i] = 1'b0; req_wen[i] = 1'b0; pending[i] = 1'b0;
      end
    end
  endtask

  task automatic wait_round();
    int c;
    c = 0;
    while (pending != 0 && c < 300) begin step(); c++; end
    if (pending != 0) begin req_ren = '0; req_wen = '0; pending = '0; end
    step();
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    ram_ready = 1'b0; in_txn = 1'b0;
    req_ren = '0; req_wen = '0; pending = '0;
    exp_q.delete();
    model_rr = 0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  // Monitor / scoreboard
  exp_t        cur;
  bit          cur_valid = 1'b0, mon_in = 1'b0, prev_ready = 1'b0, end_done = 1'b0;
  logic [31:0] model_load = '0;
  int          wd = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  always @(negedge CLK or negedge nRST) begin
    if (!nRST) begin
      #1;
      chk("reset_ram_ren", ram_ren, 0);
      chk("reset_ram_wen", ram_wen, 0);
      chk("reset_ram_addr", ram_addr, 0);
      chk("reset_ram_store", ram_store, 0);
      chk("reset_req_load", req_load, 0);
      chk("reset_req_hit", req_hit, 0);
      chk("reset_grant_id", grant_id, 0);
      chk("reset_busy", busy, 0);
      cur_valid = 1'b0; mon_in = 1'b0; prev_ready = 1'b0; model_load = '0; wd = 0;
    end else begin
      chk("strobe_exclusive", ram_ren & ram_wen, 0);
      chk("busy", busy, ram_ren | ram_wen);
      chk("req_wait", req_wait, (req_ren | req_wen) & ~req_hit);
      if ((ram_ren | ram_wen) && !mon_in) begin
        mon_in = 1'b1;
        chk("grant_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          cur_valid = 1'b1;
          chk("grant_id", grant_id, cur.id);
          chk("ram_wen", ram_wen, cur.wr);
          chk("ram_addr", ram_addr, cur.addr);
          if (cur.wr) chk("ram_store", ram_store, cur.store);
        end
      end
      if (!(ram_ren | ram_wen)) mon_in = 1'b0;
      chk("hit_latency", req_hit != 0, prev_ready);
      if (req_hit != 0 && cur_valid) begin
        chk("req_hit", req_hit, 1 << cur.id);
        if (!cur.wr) model_load = resp_data;
        cur_valid = 1'b0;
        wd = 0;
      end
      chk("req_load", req_load, model_load);
      prev_ready = ram_ready;
      if (cur_valid || exp_q.size() != 0) wd++; else wd = 0;
      if (wd == 151) begin
        chk("progress_timeout", wd, 150);
        exp_q.delete(); cur_valid = 1'b0; wd = 0;
      end
      if (end_chk && !end_done) begin
        end_done = 1'b1;
        chk("queue_drained", exp_q.size() + int'(cur_valid), 0);
      end
    end
  end

  initial begin
    nRST = 1'b1;
    req_ren = '0; req_wen = '0; req_addr = '0; req_store = '0;
    ram_ready = 1'b0; ram_load = '0; resp_data = '0;
    pending = '0; model_rr = 0; force_on = 1'b0; force_d = 0; force_data = '0;
    in_txn = 1'b0; cnt = 0; end_chk = 1'b0;
    clear_r();
    #1 nRST = 1'b0;
    repeat (3) @(posedge CLK);
    #1 nRST = 1'b1;

    // Single read from requester 1, RAM ready two cycles after the strobe.
    clear_r(); set_req(1, 1, 0, 32'h40, 32'h0);
    force_on = 1'b1; force_d = 2; force_data = 32'hDEADBEEF;
    issue(); wait_round();
    force_on = 1'b0;

    // All four read together from reset.
    do_reset(); clear_r();
    for (int i = 0; i < N; i++) set_req(i, 1, 0, $urandom, $urandom);
    issue(); wait_round();

    // Fairness: 2 alone, then 0 and 3 together.
    clear_r(); set_req(2, 1, 0, 32'h200, 32'h0); issue(); wait_round();
    clear_r(); set_req(0, 1, 0, 32'h300, 32'h0); set_req(3, 1, 0, 32'h304, 32'h0);
    issue(); wait_round();

    // Write precedence when ren and wen are both set.
    clear_r(); set_req(0, 1, 1, 32'h80, 32'h12345678); issue(); wait_round();

    // Random rounds.
    for (int r = 0; r < 25; r++) begin
      logic [N-1:0] set;
      int m;
      clear_r();
      set = N'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        if (set[i]) begin
          m = $urandom_range(0, 2);
          set_req(i, m != 1, m != 0, $urandom, $urandom);
        end
      end
      issue(); wait_round();
    end

    // Reset while the RAM access is in flight; held requests re-arbitrate from index 0.
    do_reset(); clear_r(); set_req(0, 1, 0, 32'h500, 32'h0); issue(); wait_round();
    clear_r(); set_req(0, 1, 0, 32'h600, 32'h0); set_req(3, 0, 1, 32'h604, 32'hCAFE0003);
    issue();
    force_on = 1'b1; force_d = 1000;
    for (int c = 0; c < 20 && !(ram_ren | ram_wen); c++) step();
    #2 nRST = 1'b0;
    exp_q.delete(); model_rr = 0; in_txn = 1'b0; ram_ready = 1'b0; force_on = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    plan_order(pending);
    nRST = 1'b1;
    wait_round();

    // Requesters 0 and 3 together from reset (data priority decides the order).
    do_reset(); clear_r();
    set_req(0, 1, 0, 32'h700, 32'h0); set_req(3, 1, 0, 32'h704, 32'h0);
    issue(); wait_round();

    end_chk = 1'b1;
    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
